// File: rtl/uart_parity_rx.sv
// Receiver for the parity-protected UART frame: start, parity, 8 data bits LSB-first, stop.
// Samples mid-bit, checks parity and stop, and delivers each byte with a one-cycle valid strobe.
module uart_parity_rx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned H    = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned BW   = 4;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] H_M1   = (H == 0) ? '0 : CW'(H - 1);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(9);
  localparam logic [BW-1:0] STOP_BIT      = BW'(10);

  typedef enum logic [2:0] {
    IDLE,
    START,
    PARITY,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          rx_s;
  logic          sample;

  assign rx_s   = sync_q[1];
  assign sample = (cnt_q == '0);

  // State register and all output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: cnt_q counts down to the next mid-bit sample point
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], in};
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // With H == 0 the start bit is sampled in the detection cycle itself
          if (H == 0) begin
            state_d = PARITY;
            bit_d   = BW'(1);
            cnt_d   = RELOAD;
          end else begin
            state_d = START;
            bit_d   = '0;
            cnt_d   = H_M1;
          end
        end
      end
      START, PARITY, DATA, STOP: begin
        if (!sample) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = RELOAD;
          if (bit_q != STOP_BIT) begin
            bit_d = bit_q + 1'b1;
          end
          case (state_q)
            START:   state_d = rx_s ? IDLE : PARITY;
            PARITY: begin
              par_d   = rx_s;
              state_d = DATA;
            end
            DATA: begin
              shreg_d = {rx_s, shreg_q[7:1]};
              if (bit_q == LAST_DATA_BIT) begin
                state_d = STOP;
              end
            end
            default: begin
              data_d  = shreg_q;
              perr_d  = par_q ^ (^shreg_q) ^ PARITY_ODD;
              ferr_d  = ~rx_s;
              valid_d = 1'b1;
              state_d = rx_s ? IDLE : WAIT_HIGH;
            end
          endcase
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_parity_rx.sv
// Scoreboard bench for uart_parity_rx: one instance at 1 clk/bit even parity,
// one at 16 clk/bit odd parity; monitors pop expected bytes on each valid.
module tb_uart_parity_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_a = 1'b1;
  logic       in_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vcnt_a = 0;
  int   vcnt_b = 0;
  int   t_start = 0;
  int   vtimes_a[$];
  exp_t q_a[$];
  exp_t q_b[$];

  uart_parity_rx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .data(data_a), .valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_parity_rx #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .data(data_b), .valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    if (rst_n && valid_a) begin
      exp_t e;
      vcnt_a++;
      vtimes_a.push_back(cyc);
      if (q_a.size() == 0) begin
        chk("unexpected_valid_a", {22'd0, data_a, perr_a, ferr_a}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        chk("frame_a", {22'd0, data_a, perr_a, ferr_a}, {22'd0, e.d, e.pe, e.fe});
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (rst_n && valid_b) begin
      exp_t e;
      vcnt_b++;
      if (q_b.size() == 0) begin
        chk("unexpected_valid_b", {22'd0, data_b, perr_b, ferr_b}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        chk("frame_b", {22'd0, data_b, perr_b, ferr_b}, {22'd0, e.d, e.pe, e.fe});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drive the first nbits of a frame (bits[0]=start .. bits[10]=stop)
  task automatic drive(input bit sel, input logic [10:0] bits, input int nbits);
    int cpb;
    cpb = sel ? 16 : 1;
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk);
      #1;
      if (sel) in_b = bits[k];
      else     in_a = bits[k];
      if (k == 0) t_start = cyc;
      repeat (cpb - 1) @(posedge clk);
    end
  endtask

  task automatic frame(input bit sel, input logic [7:0] d, input logic p, input logic s,
                       input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    drive(sel, {s, d, p, 1'b0}, 11);
  endtask

  initial begin
    int v0;
    int ts;
    int bound;

    // Reset state
    idle(3);
    @(negedge clk);
    chk("reset_a", {19'd0, data_a, valid_a, perr_a, ferr_a, busy_a}, 32'd0);
    chk("reset_b", {19'd0, data_b, valid_b, perr_b, ferr_b, busy_b}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // 0xA5, good parity; latency 2 sync + 11 cycles
    vtimes_a.delete();
    frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    ts = t_start;
    idle(5);
    chk("latency_a", vtimes_a[0] - ts, 32'd13);

    // Parity bit flipped
    frame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Stop bit low, line held low (break)
    v0 = vcnt_a;
    frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    chk("break_single_valid", vcnt_a - v0, 32'd1);
    chk("break_busy_held", {31'd0, busy_a}, 32'd1);
    @(posedge clk);
    #1 in_a = 1'b1;
    idle(10);
    @(negedge clk);
    chk("break_no_new_valid", vcnt_a - v0, 32'd1);
    chk("break_busy_released", {31'd0, busy_a}, 32'd0);

    // Back-to-back frames, no idle gap
    vtimes_a.delete();
    frame(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    chk("b2b_count", vtimes_a.size(), 32'd3);
    chk("b2b_gap1", vtimes_a[1] - vtimes_a[0], 32'd11);
    chk("b2b_gap2", vtimes_a[2] - vtimes_a[1], 32'd11);

    // Odd parity, 16 clk/bit
    frame(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(20);

    // 4-cycle glitch in IDLE is a false start
    v0 = vcnt_b;
    @(posedge clk);
    #1 in_b = 1'b0;
    repeat (4) @(posedge clk);
    #1 in_b = 1'b1;
    chk("glitch_busy_seen", {31'd0, busy_b}, 32'd1);
    idle(30);
    @(negedge clk);
    chk("glitch_busy_cleared", {31'd0, busy_b}, 32'd0);
    chk("glitch_no_valid", vcnt_b - v0, 32'd0);

    // Reset in the middle of a frame's data bits
    drive(1'b0, {1'b1, 8'h5A, 1'b0, 1'b0}, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset_a", {19'd0, data_a, valid_a, perr_a, ferr_a, busy_a}, 32'd0);
    chk("midreset_b", {19'd0, data_b, valid_b, perr_b, ferr_b, busy_b}, 32'd0);
    in_a = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Drain scoreboards with a bounded wait
    bound = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && bound < 500) begin
      @(posedge clk);
      bound++;
    end
    chk("drain_a", q_a.size(), 32'd0);
    chk("drain_b", q_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
